// File: rtl/h_dmux_dispatch_pkg.sv
// Shared types and constants for the h_dmux_dispatch single-entry dispatcher.
// Also holds the 1:2 demux primitive the 4-way expander is built from.
package h_dispatch_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int NDEST  = 4;
    localparam int DEST_W = 2;
    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // 1:2 demux: bit 1 carries en when sel is high, bit 0 when sel is low.
    function automatic logic [1:0] dmux2(input logic en, input logic sel);
        dmux2 = {en & sel, en & ~sel};
    endfunction

endpackage

// File: rtl/h_dmux_dispatch_if.sv
// Producer/consumer handshake bundle for h_dmux_dispatch.
// master = the environment (producer and consumers), slave = the dispatcher.
interface h_dmux_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/h_dmux_dispatch_dmux4_way.sv
// One-hot expander of a single valid onto four consumers under a 2-bit select,
// built as a tree of 1:2 demux stages.
module h_dmux4_way
    import h_dispatch_pkg::*;
(
    input  logic              valid_i,
    input  logic [DEST_W-1:0] sel_i,
    output logic [NDEST-1:0]  valid_o
);
    logic [1:0] stage_s;

    // High select bit picks the pair, low select bit picks within the pair.
    always_comb begin
        stage_s      = dmux2(valid_i, sel_i[1]);
        valid_o[1:0] = dmux2(stage_s[0], sel_i[0]);
        valid_o[3:2] = dmux2(stage_s[1], sel_i[0]);
    end
endmodule

// File: rtl/h_dmux_dispatch.sv
// Single-entry dispatcher routing one producer word to one of four consumers,
// dropping and counting words that wait too long. Option: H_DISPATCH_RR_EN.
module h_dmux_dispatch
    import h_dispatch_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    h_dmux_dispatch_if.slave  bus,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam logic               TO_EN   = (TIMEOUT != 0);
    localparam logic [DROP_W-1:0]  TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    data_q,  data_d;
    logic [DEST_W-1:0]   dest_q,  dest_d;
    logic [7:0]          wait_q,  wait_d;
    logic [DROP_W-1:0]   drop_q,  drop_d;
    logic                xfer_s;
    logic                expire_s;
    logic [DEST_W-1:0]   pick_s;

`ifdef H_DISPATCH_RR_EN
    logic [DEST_W-1:0]   rr_q, rr_d;
    logic [DEST_W-1:0]   unused_dest_s;

    assign unused_dest_s = bus.in_dest;
    assign pick_s        = rr_q;
`else
    assign pick_s        = bus.in_dest;
`endif

    // Next-state, capture, timeout and drop-count logic.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dest_d   = dest_q;
        wait_d   = wait_q;
        drop_d   = drop_q;
`ifdef H_DISPATCH_RR_EN
        rr_d     = rr_q;
`endif
        xfer_s   = (state_q == ST_HOLD) && bus.out_ready[dest_q];
        expire_s = TO_EN && (wait_q == TO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_HOLD;
                    data_d  = bus.in_data;
                    dest_d  = pick_s;
                    wait_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A transfer always wins over an expiring wait in the same cycle.
                if (xfer_s) begin
                    state_d = ST_IDLE;
`ifdef H_DISPATCH_RR_EN
                    rr_d    = rr_q + 2'd1;
`endif
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                    drop_d  = (drop_q == DROP_MAX) ? DROP_MAX : drop_q + 8'd1;
`ifdef H_DISPATCH_RR_EN
                    rr_d    = rr_q + 2'd1;
`endif
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dest_q  <= '0;
            wait_q  <= 8'd0;
            drop_q  <= 8'd0;
`ifdef H_DISPATCH_RR_EN
            rr_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            wait_q  <= wait_d;
            drop_q  <= drop_d;
`ifdef H_DISPATCH_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_HOLD);
    assign bus.out_data = data_q;
    assign drop_cnt     = drop_q;

    h_dmux4_way u_dmux4 (
        .valid_i (state_q == ST_HOLD),
        .sel_i   (dest_q),
        .valid_o (bus.out_valid)
    );
endmodule

// File: tb/tb_h_dmux_dispatch.sv
// Scoreboard bench for h_dmux_dispatch: a long-timeout instance for routing and
// backpressure, plus a TIMEOUT=4 instance for drop behaviour.
module tb_h_dmux_dispatch;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy_m, busy_t;
    logic [7:0] drop_m, drop_t;

    h_dmux_dispatch_if #(.WIDTH(16)) bus ();
    h_dmux_dispatch_if #(.WIDTH(16)) tbus ();

    h_dmux_dispatch #(.WIDTH(16), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy_m), .drop_cnt(drop_m));

    h_dmux_dispatch #(.WIDTH(16), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .bus(tbus.slave), .busy(busy_t), .drop_cnt(drop_t));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dest;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_m  = 0;
    int   rr_t  = 0;

    function automatic logic [3:0] oh(input logic [1:0] d);
        oh = 4'b0001 << d;
    endfunction

    function automatic logic [1:0] pick(input int ptr, input logic [1:0] req);
        pick = req;
`ifdef H_DISPATCH_RR_EN
        pick = 2'(ptr);
`endif
    endfunction

    // Advance one cycle; any transfer on the main instance is scored first.
    task automatic step();
        exp_t e;
        if (!reset && ((bus.out_valid & bus.out_ready) != 4'b0000)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_xfer got valid=%b data=%h, none expected", bus.out_valid, bus.out_data);
            end else begin
                e = sb.pop_front();
                if (bus.out_valid !== oh(e.dest) || bus.out_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_xfer got valid=%b data=%h exp valid=%b data=%h",
                             bus.out_valid, bus.out_data, oh(e.dest), e.data);
                end
                rr_m = (rr_m + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
        n_vec++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
        n_vec++; if (busy_m !== 1'b0 || busy_t !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b%b exp=00", busy_m, busy_t); end
        n_vec++; if (drop_m !== 8'd0 || drop_t !== 8'd0) begin n_err++; $display("FAIL reset_drop got=%0d/%0d exp=0/0", drop_m, drop_t); end
        reset = 1'b0;
        rr_m = 0;
        rr_t = 0;
    endtask

    task automatic test_routing();
        logic [1:0] d;
        d = pick(rr_m, 2'd2);
        bus.out_ready = oh(d);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        bus.in_dest   = 2'd2;
        sb.push_back('{d, 16'hBEEF});
        step();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== oh(d)) begin n_err++; $display("FAIL route_valid got=%b exp=%b", bus.out_valid, oh(d)); end
        n_vec++; if (bus.out_data !== 16'hBEEF) begin n_err++; $display("FAIL route_data got=%h exp=beef", bus.out_data); end
        n_vec++; if (busy_m !== 1'b1 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL route_hold got busy=%b in_ready=%b exp 1/0", busy_m, bus.in_ready); end
        step();
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL route_idle got in_ready=%b valid=%b exp 1/0000", bus.in_ready, bus.out_valid); end
        n_vec++; if (bus.out_data !== 16'hBEEF) begin n_err++; $display("FAIL route_data_kept got=%h exp=beef", bus.out_data); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL route_sb_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [1:0] d;
        d = pick(rr_m, 2'd1);
        bus.out_ready = ~oh(d);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_dest   = 2'd1;
        sb.push_back('{d, 16'h1234});
        step();
        bus.in_valid = 1'b0;
        bus.in_dest  = 2'd0;
        bus.in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.out_valid !== oh(d) || bus.out_data !== 16'h1234) begin
                n_err++;
                $display("FAIL bp_stall%0d got valid=%b data=%h exp valid=%b data=1234", i, bus.out_valid, bus.out_data, oh(d));
            end
            step();
        end
        bus.out_ready = oh(d);
        n_vec++; if (busy_m !== 1'b1) begin n_err++; $display("FAIL bp_still_busy got=%b exp=1", busy_m); end
        step();
        n_vec++; if (bus.in_ready !== 1'b1 || sb.size() != 0) begin n_err++; $display("FAIL bp_done got in_ready=%b sb=%0d exp 1/0", bus.in_ready, sb.size()); end
    endtask

    task automatic test_reset_mid_hold();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h5A5A;
        bus.in_dest   = 2'd0;
        step();
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rr_m = 0;
        rr_t = 0;
        n_vec++; if (bus.out_valid !== 4'b0000 || busy_m !== 1'b0) begin n_err++; $display("FAIL rst_hold got valid=%b busy=%b exp 0000/0", bus.out_valid, busy_m); end
        n_vec++; if (bus.in_ready !== 1'b1 || drop_m !== 8'd0) begin n_err++; $display("FAIL rst_hold got in_ready=%b drop=%0d exp 1/0", bus.in_ready, drop_m); end
        n_vec++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL rst_hold_data got=%h exp=0000", bus.out_data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] d;
        bus.out_ready = 4'b1111;
        bus.in_dest   = 2'd3;
        for (int i = 0; i < 5; i++) begin
            d = pick(rr_m, 2'd3);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hA000 + 16'(i);
            sb.push_back('{d, 16'hA000 + 16'(i)});
            step();
            n_vec++;
            if (bus.out_valid !== oh(d) || busy_m !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_word%0d got valid=%b busy=%b exp valid=%b busy=1", i, bus.out_valid, busy_m, oh(d));
            end
            step();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1 || sb.size() != 0) begin n_err++; $display("FAIL b2b_done got in_ready=%b sb=%0d exp 1/0", bus.in_ready, sb.size()); end
    endtask

    task automatic test_timeout();
        logic [1:0] d;
        d = pick(rr_t, 2'd1);
        tbus.out_ready = 4'b0000;
        tbus.in_valid  = 1'b1;
        tbus.in_data   = 16'h0F0F;
        tbus.in_dest   = 2'd1;
        step();
        tbus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (tbus.out_valid !== oh(d)) begin n_err++; $display("FAIL to_present%0d got=%b exp=%b", i, tbus.out_valid, oh(d)); end
            step();
        end
        n_vec++; if (tbus.out_valid !== 4'b0000 || tbus.in_ready !== 1'b1) begin n_err++; $display("FAIL to_idle got valid=%b in_ready=%b exp 0000/1", tbus.out_valid, tbus.in_ready); end
        n_vec++; if (drop_t !== 8'd1) begin n_err++; $display("FAIL to_drop got=%0d exp=1", drop_t); end
        rr_t = (rr_t + 1) % 4;
    endtask

    task automatic test_timeout_race();
        logic [1:0] d;
        d = pick(rr_t, 2'd2);
        tbus.out_ready = 4'b0000;
        tbus.in_valid  = 1'b1;
        tbus.in_data   = 16'hC0DE;
        tbus.in_dest   = 2'd2;
        step();
        tbus.in_valid = 1'b0;
        step();
        step();
        step();
        tbus.out_ready = oh(d);
        n_vec++; if (tbus.out_valid !== oh(d)) begin n_err++; $display("FAIL race_4th got=%b exp=%b", tbus.out_valid, oh(d)); end
        step();
        tbus.out_ready = 4'b0000;
        n_vec++; if (tbus.in_ready !== 1'b1 || drop_t !== 8'd1) begin n_err++; $display("FAIL race_xfer got in_ready=%b drop=%0d exp 1/1", tbus.in_ready, drop_t); end
        rr_t = (rr_t + 1) % 4;
    endtask

    task automatic test_drop_saturate();
        int exp_drop;
        tbus.out_ready = 4'b0000;
        for (int k = 2; k <= 300; k++) begin
            tbus.in_valid = 1'b1;
            step();
            tbus.in_valid = 1'b0;
            repeat (4) step();
            exp_drop = (k > 255) ? 255 : k;
            n_vec++;
            if (drop_t !== 8'(exp_drop)) begin
                n_err++;
                $display("FAIL sat_drop%0d got=%0d exp=%0d", k, drop_t, exp_drop);
            end
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = 16'h0000;
        bus.in_dest    = 2'd0;
        bus.out_ready  = 4'b0000;
        tbus.in_valid  = 1'b0;
        tbus.in_data   = 16'h0000;
        tbus.in_dest   = 2'd0;
        tbus.out_ready = 4'b0000;
        test_reset();
        test_routing();
        test_backpressure();
        test_reset_mid_hold();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_drop_saturate();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_residue got=%0d exp=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
